// File: rtl/fp_pkg.sv
// Shared FP32 constants and the state type of the sequential float-to-int converter.
// Used by fp32_unpack, fp_to_int_seq and (later) the FP adder.
package fp_pkg;

  localparam int XLEN       = 32;
  localparam int FP32_BIAS  = 127;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  localparam logic [31:0] INT32_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN  = 32'h8000_0000;
  localparam logic [31:0] UINT32_MAX = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } f2i_state_e;

endpackage

// File: rtl/fp_to_int_seq_if.sv
// Start/busy/done handshake bundle of fp_to_int_seq; master = requester, slave = converter.
interface fp_to_int_seq_if;

  logic                     start;
  logic                     is_signed;
  logic [fp_pkg::XLEN-1:0]  A;
  logic                     busy;
  logic                     done;
  logic [fp_pkg::XLEN-1:0]  result;
  logic                     invalid;
  logic                     inexact;

  modport master (
    output start, is_signed, A,
    input  busy, done, result, invalid, inexact
  );

  modport slave (
    input  start, is_signed, A,
    output busy, done, result, invalid, inexact
  );

endinterface

// File: rtl/fp32_unpack.sv
// Combinational binary32 field splitter with hidden-bit mantissa and class flags.
module fp32_unpack
  import fp_pkg::*;
(
  input  logic [31:0]           a_i,
  output logic                  sign_o,
  output logic [FP32_EXP_W-1:0] exp_o,
  output logic [FP32_MAN_W:0]   man_o,
  output logic                  is_zero_o,
  output logic                  is_denorm_o,
  output logic                  is_inf_o,
  output logic                  is_nan_o
);

  logic exp_all0;
  logic exp_all1;
  logic frac_nz;

  assign sign_o   = a_i[31];
  assign exp_o    = a_i[FP32_MAN_W +: FP32_EXP_W];
  assign frac_nz  = |a_i[FP32_MAN_W-1:0];
  assign exp_all0 = (exp_o == '0);
  assign exp_all1 = &exp_o;

  assign man_o       = {~exp_all0, a_i[FP32_MAN_W-1:0]};
  assign is_zero_o   = exp_all0 & ~frac_nz;
  assign is_denorm_o = exp_all0 &  frac_nz;
  assign is_inf_o    = exp_all1 & ~frac_nz;
  assign is_nan_o    = exp_all1 &  frac_nz;

endmodule

// File: rtl/fp_to_int_seq.sv
// Multi-cycle binary32 -> int32/uint32 converter (round toward zero), one shift bit per cycle.
// Define FP2INT_INEXACT_EN to build the sticky/inexact logic; otherwise inexact is tied low.
module fp_to_int_seq
  import fp_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  fp_to_int_seq_if.slave bus
);

  logic                  sign;
  logic [FP32_EXP_W-1:0] exp_b;
  logic [FP32_MAN_W:0]   man;
  logic                  is_zero, is_denorm, is_inf, is_nan;

  fp32_unpack u_unpack (
    .a_i        (bus.A),
    .sign_o     (sign),
    .exp_o      (exp_b),
    .man_o      (man),
    .is_zero_o  (is_zero),
    .is_denorm_o(is_denorm),
    .is_inf_o   (is_inf),
    .is_nan_o   (is_nan)
  );

  logic signed [8:0] e_unb;
  logic              tiny;
  logic              exact_min;
  logic              cls_left;
  logic [4:0]        cls_n;
  logic              cls_special;
  logic              cls_inv;
  logic [31:0]       cls_res;
  logic              accept;

  assign e_unb     = $signed({1'b0, exp_b}) - 9'(FP32_BIAS);
  assign tiny      = is_zero | is_denorm | (e_unb < 9'sd0);
  assign exact_min = sign & (man == {1'b1, {FP32_MAN_W{1'b0}}});
  assign cls_left  = (e_unb >= 9'sd23);
  assign cls_n     = cls_left ? 5'(e_unb - 9'sd23) : 5'(9'sd23 - e_unb);

  // Cases that finish without shifting: NaN, saturation, and |A| < 1.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    cls_special = 1'b1;
    cls_inv     = 1'b0;
    cls_res     = '0;
    if (is_nan) begin
      cls_res = bus.is_signed ? INT32_MAX : UINT32_MAX;
      cls_inv = 1'b1;
    end else if (bus.is_signed) begin
      if (is_inf || (e_unb > 9'sd31) || ((e_unb == 9'sd31) && !exact_min)) begin
        cls_res = sign ? INT32_MIN : INT32_MAX;
        cls_inv = 1'b1;
      end else if (!tiny) begin
        cls_special = 1'b0;
      end
    end else begin
      if (sign && (e_unb >= 9'sd0)) begin
        cls_inv = 1'b1;
      end else if (is_inf || (e_unb >= 9'sd32)) begin
        cls_res = UINT32_MAX;
        cls_inv = 1'b1;
      end else if (!tiny) begin
        cls_special = 1'b0;
      end
    end
  end

  f2i_state_e  state_q;
  logic        busy_q, done_q, invalid_q, inv_pend_q, neg_q, left_q;
  logic [31:0] w_q, result_q;
  logic [4:0]  n_q;

  assign accept = (state_q == ST_IDLE) & bus.start;

  // Special cases park their final value in W with n=0, so they take the same one-cycle exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      invalid_q  <= 1'b0;
      inv_pend_q <= 1'b0;
      neg_q      <= 1'b0;
      left_q     <= 1'b0;
      w_q        <= '0;
      n_q        <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q    <= ST_SHIFT;
            busy_q     <= 1'b1;
            invalid_q  <= 1'b0;
            inv_pend_q <= cls_inv;
            if (cls_special) begin
              w_q    <= cls_res;
              neg_q  <= 1'b0;
              left_q <= 1'b0;
              n_q    <= '0;
            end else begin
              w_q    <= {{(32-FP32_MAN_W-1){1'b0}}, man};
              neg_q  <= sign;
              left_q <= cls_left;
              n_q    <= cls_n;
            end
          end
        end
        ST_SHIFT: begin
          if (n_q != 5'd0) begin
            w_q <= left_q ? {w_q[30:0], 1'b0} : {1'b0, w_q[31:1]};
            n_q <= n_q - 5'd1;
          end else begin
            result_q  <= neg_q ? -w_q : w_q;
            invalid_q <= inv_pend_q;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.invalid = invalid_q;

`ifdef FP2INT_INEXACT_EN
  logic sticky_q, inexact_q;

  // A nonzero tiny operand is inexact from the start; the right shift ORs in every dropped bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q  <= 1'b0;
      inexact_q <= 1'b0;
    end else if (accept) begin
      sticky_q  <= tiny & ~is_zero;
      inexact_q <= 1'b0;
    end else if (state_q == ST_SHIFT) begin
      if (n_q != 5'd0) sticky_q  <= sticky_q | (~left_q & w_q[0]);
      else             inexact_q <= sticky_q;
    end
  end

  assign bus.inexact = inexact_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign bus.inexact   = 1'b0;
`endif

endmodule

// File: tb/tb_fp_to_int_seq.sv
// Self-checking bench for fp_to_int_seq: arithmetic reference model plus directed vectors.
module tb_fp_to_int_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_to_int_seq_if bus();

  fp_to_int_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic nx_cfg(input logic v);
`ifdef FP2INT_INEXACT_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  // Reference: exact value m*2^(E-23) truncated toward zero, then range-checked.
  function automatic void model(input logic [31:0] a, input logic sg,
                                output logic [31:0] r, output logic inv,
                                output logic nx, output int lat);
    int     ex, e;
    longint m, mag, val, one;
    logic   lost;
    ex   = int'(a[30:23]);
    e    = ex - 127;
    m    = longint'({(ex != 0), a[22:0]});
    one  = 1;
    lost = 1'b0;
    r    = '0;
    inv  = 1'b0;
    nx   = 1'b0;
    lat  = 1;
    if (ex == 255 && a[22:0] != 0) begin
      r   = sg ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
      inv = 1'b1;
      return;
    end
    if (ex == 255 || e > 40) mag = one <<< 40;
    else if (e < 0) begin
      mag  = 0;
      lost = (m != 0);
    end else if (e >= 23) mag = m <<< (e - 23);
    else begin
      mag  = m >>> (23 - e);
      lost = (m & ((one <<< (23 - e)) - 1)) != 0;
    end
    val = a[31] ? -mag : mag;
    if (sg) begin
      if (val > 64'sd2147483647)       begin r = 32'h7FFF_FFFF; inv = 1'b1; end
      else if (val < -64'sd2147483648) begin r = 32'h8000_0000; inv = 1'b1; end
      else r = val[31:0];
    end else begin
      if (val < 0)                     begin r = 32'h0;         inv = 1'b1; end
      else if (val > 64'sd4294967295)  begin r = 32'hFFFF_FFFF; inv = 1'b1; end
      else r = val[31:0];
    end
    nx  = nx_cfg(inv ? 1'b0 : lost);
    lat = (inv || mag == 0) ? 1 : (((e >= 23) ? (e - 23) : (23 - e)) + 1);
  endfunction

  // Transaction-level expectation, advanced on the same edges the DUT sees.
  logic        m_busy = 0, m_done = 0, m_inv = 0, m_nx = 0;
  logic [31:0] m_res = 0;
  int          m_left = 0;
  logic [31:0] p_res;
  logic        p_inv, p_nx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_res = 0; m_inv = 0; m_nx = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1;
          m_res = p_res; m_inv = p_inv; m_nx = p_nx;
        end
      end else if (bus.start) begin
        model(bus.A, bus.is_signed, p_res, p_inv, p_nx, m_left);
        m_busy = 1; m_inv = 0; m_nx = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", bus.busy, m_busy);
    check("done", bus.done, m_done);
    if (!m_busy) begin
      check("result", bus.result, m_res);
      check("invalid", bus.invalid, m_inv);
      check("inexact", bus.inexact, m_nx);
    end
  end

  task automatic launch(input logic [31:0] a, input logic sg);
    @(posedge clk); #2;
    bus.start = 1'b1; bus.A = a; bus.is_signed = sg;
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin lat = c; break; end
    end
  endtask

  task automatic run(input logic [31:0] a, input logic sg, input logic [31:0] lit_res,
                     input logic lit_inv, input logic lit_nx, input int lit_lat);
    logic [31:0] r; logic inv, nx; int lat, got_lat;
    model(a, sg, r, inv, nx, lat);
    check("model_res", r, lit_res);
    check("model_inv", inv, lit_inv);
    check("model_nx", nx, nx_cfg(lit_nx));
    check("model_lat", lat, lit_lat);
    launch(a, sg);
    wait_done(got_lat);
    check("latency", got_lat, lit_lat);
    check("lit_result", bus.result, lit_res);
    check("lit_invalid", bus.invalid, lit_inv);
    check("lit_inexact", bus.inexact, nx_cfg(lit_nx));
  endtask

  initial begin
    int lat;
    bus.start = 1'b0; bus.A = '0; bus.is_signed = 1'b0;
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_result", bus.result, 32'h0);
    check("rst_invalid", bus.invalid, 1'b0);
    check("rst_inexact", bus.inexact, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(32'h40490FDB, 1, 32'h0000_0003, 0, 1, 23);
    run(32'hC2F60000, 1, 32'hFFFF_FF85, 0, 0, 18);
    run(32'hC2F60000, 0, 32'h0000_0000, 1, 0, 1);
    run(32'h4F000000, 1, 32'h7FFF_FFFF, 1, 0, 1);
    run(32'h4F000000, 0, 32'h8000_0000, 0, 0, 9);
    run(32'hCF000000, 1, 32'h8000_0000, 0, 0, 9);
    run(32'hCF000001, 1, 32'h8000_0000, 1, 0, 1);
    run(32'h7FC00000, 1, 32'h7FFF_FFFF, 1, 0, 1);
    run(32'h7FC00000, 0, 32'hFFFF_FFFF, 1, 0, 1);
    run(32'hBF000000, 0, 32'h0000_0000, 0, 1, 1);
    run(32'h80000000, 0, 32'h0000_0000, 0, 0, 1);
    run(32'h00000001, 1, 32'h0000_0000, 0, 1, 1);
    run(32'hFF800000, 1, 32'h8000_0000, 1, 0, 1);
    run(32'hFF800000, 0, 32'h0000_0000, 1, 0, 1);
    run(32'h4F800000, 0, 32'hFFFF_FFFF, 1, 0, 1);
    run(32'h4EFFFFFF, 1, 32'h7FFF_FF80, 0, 0, 8);
    run(32'h4B000001, 1, 32'h0080_0001, 0, 0, 1);
    run(32'h3FFFFFFF, 0, 32'h0000_0001, 0, 1, 24);
    run(32'hC0600000, 1, 32'hFFFF_FFFD, 0, 1, 23);

    // Second start during SHIFT must be ignored.
    launch(32'h3F800000, 1);
    lat = -1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (c == 3) begin bus.start = 1'b1; bus.A = 32'h41200000; end
      else bus.start = 1'b0;
      if (bus.done === 1'b1) begin lat = c; break; end
    end
    bus.start = 1'b0;
    check("ignore_lat", lat, 24);
    check("ignore_result", bus.result, 32'h0000_0001);
    check("ignore_invalid", bus.invalid, 1'b0);

    // Asynchronous reset mid-conversion aborts without a done pulse.
    launch(32'h3F800000, 1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_result", bus.result, 32'h0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_done", bus.done, 1'b0);
    run(32'h41200000, 1, 32'h0000_000A, 0, 0, 21);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
